// File: rtl/ibex_wb_pkg.sv
// Shared types and helpers for the register-file write-back arbiter.
package ibex_wb_pkg;

   localparam int unsigned WbMaxAddrWidth = 5;
   localparam int unsigned WbMaxPtrWidth  = 16;

   typedef enum logic [1:0] {
      WB_SRC_NONE = 2'd0,
      WB_SRC_EX   = 2'd1,
      WB_SRC_LSU  = 2'd2
   } wb_src_e;

   typedef struct packed {
      logic                      valid;
      logic [WbMaxAddrWidth-1:0] waddr;
   } ld_entry_t;

   // Wrap-bit pointers: full when only the top bit of the ptr_w-bit pointers differs.
   function automatic logic ptr_full(input logic [WbMaxPtrWidth-1:0] wptr,
                                     input logic [WbMaxPtrWidth-1:0] rptr,
                                     input int unsigned              ptr_w);
      logic [WbMaxPtrWidth-1:0] mask;
      logic [WbMaxPtrWidth-1:0] msb;
      mask = (WbMaxPtrWidth'(1) << ptr_w) - WbMaxPtrWidth'(1);
      msb  = WbMaxPtrWidth'(1) << (ptr_w - 32'd1);
      return ((wptr ^ rptr) & mask) == msb;
   endfunction

endpackage

// File: rtl/ibex_wb_ld_fifo.sv
// In-order FIFO of outstanding load destinations; every slot is exposed so the
// arbiter can compare pending destinations against decode read addresses.
module ibex_wb_ld_fifo
   import ibex_wb_pkg::*;
#(
   parameter int unsigned AddrWidth = 5,
   parameter int unsigned LoadDepth = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           push_i,
   input  logic [AddrWidth-1:0]           push_waddr_i,
   input  logic                           pop_i,
   output logic                           full_o,
   output logic                           empty_o,
   output logic [AddrWidth-1:0]           head_waddr_o,
   output logic [LoadDepth-1:0]           slot_valid_o,
   output logic [LoadDepth*AddrWidth-1:0] slot_waddr_o
);

   localparam int unsigned PtrWidth = $clog2(LoadDepth) + 1;
   localparam int unsigned IdxWidth = (LoadDepth > 1) ? $clog2(LoadDepth) : 1;

   ld_entry_t           slots_r [LoadDepth];
   logic [PtrWidth-1:0] wptr_r;
   logic [PtrWidth-1:0] rptr_r;
   logic [IdxWidth-1:0] widx_s;
   logic [IdxWidth-1:0] ridx_s;

   // A single-slot FIFO has no index bits; the pointer is then just the wrap bit.
   assign widx_s = (LoadDepth > 1) ? wptr_r[IdxWidth-1:0] : '0;
   assign ridx_s = (LoadDepth > 1) ? rptr_r[IdxWidth-1:0] : '0;

   assign empty_o      = (wptr_r == rptr_r);
   assign full_o       = ptr_full(WbMaxPtrWidth'(wptr_r), WbMaxPtrWidth'(rptr_r), PtrWidth);
   assign head_waddr_o = slots_r[ridx_s].waddr[AddrWidth-1:0];

   // Slot storage and pointers; when full, a same-cycle push refills the slot being popped.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wptr_r <= '0;
         rptr_r <= '0;
         for (int i = 0; i < LoadDepth; i++) begin
            slots_r[i] <= '0;
         end
      end else begin
         if (pop_i) begin
            slots_r[ridx_s].valid <= 1'b0;
            rptr_r                <= rptr_r + PtrWidth'(1);
         end
         if (push_i) begin
            slots_r[widx_s].valid <= 1'b1;
            slots_r[widx_s].waddr <= WbMaxAddrWidth'(push_waddr_i);
            wptr_r                <= wptr_r + PtrWidth'(1);
         end
      end
   end

   // Flatten slots into vectors for the hazard comparators.
   always_comb begin
      slot_valid_o = '0;
      slot_waddr_o = '0;
      for (int i = 0; i < LoadDepth; i++) begin
         slot_valid_o[i]                          = slots_r[i].valid;
         slot_waddr_o[i*AddrWidth +: AddrWidth]   = slots_r[i].waddr[AddrWidth-1:0];
      end
   end

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// Register-file write-port master: LSU returns take priority over EX results.
// Build option IBEX_WB_BYPASS_EN adds forwarding of the in-flight RF write.
module ibex_rf_wb_arbiter
   import ibex_wb_pkg::*;
#(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned AddrWidth = 5,
   parameter int unsigned LoadDepth = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 ex_valid_i,
   input  logic [AddrWidth-1:0] ex_waddr_i,
   input  logic [DataWidth-1:0] ex_wdata_i,
   output logic                 ex_ready_o,
   input  logic                 ld_issue_i,
   input  logic [AddrWidth-1:0] ld_waddr_i,
   output logic                 ld_issue_ready_o,
   input  logic                 lsu_rvalid_i,
   input  logic [DataWidth-1:0] lsu_rdata_i,
   input  logic [AddrWidth-1:0] raddr_a_i,
   input  logic [AddrWidth-1:0] raddr_b_i,
   output logic                 hazard_a_o,
   output logic                 hazard_b_o,
`ifdef IBEX_WB_BYPASS_EN
   output logic                 fwd_a_o,
   output logic                 fwd_b_o,
   output logic [DataWidth-1:0] fwd_data_o,
`endif
   output logic [AddrWidth-1:0] rf_waddr_o,
   output logic [DataWidth-1:0] rf_wdata_o,
   output logic                 rf_we_o,
   output logic                 err_o
);

   logic                           fifo_full_s;
   logic                           fifo_empty_s;
   logic [AddrWidth-1:0]           head_waddr_s;
   logic [LoadDepth-1:0]           slot_valid_s;
   logic [LoadDepth*AddrWidth-1:0] slot_waddr_s;
   logic                           pop_s;
   logic                           push_s;
   wb_src_e                        src_s;
   logic [AddrWidth-1:0]           sel_waddr_s;
   logic [DataWidth-1:0]           sel_wdata_s;
   logic                           sel_we_s;
   logic                           pend_a_s;
   logic                           pend_b_s;
   logic                           rf_we_r;
   logic [AddrWidth-1:0]           rf_waddr_r;
   logic [DataWidth-1:0]           rf_wdata_r;
   logic                           err_r;

   assign ex_ready_o       = !lsu_rvalid_i;
   assign ld_issue_ready_o = !fifo_full_s || lsu_rvalid_i;
   assign pop_s            = lsu_rvalid_i && !fifo_empty_s;
   assign push_s           = ld_issue_i && ld_issue_ready_o;

   ibex_wb_ld_fifo #(
      .AddrWidth (AddrWidth),
      .LoadDepth (LoadDepth)
   ) u_ld_fifo (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .push_i       (push_s),
      .push_waddr_i (ld_waddr_i),
      .pop_i        (pop_s),
      .full_o       (fifo_full_s),
      .empty_o      (fifo_empty_s),
      .head_waddr_o (head_waddr_s),
      .slot_valid_o (slot_valid_s),
      .slot_waddr_o (slot_waddr_s)
   );

   // Write source select; a return with nothing outstanding writes nothing.
   always_comb begin
      src_s       = WB_SRC_NONE;
      sel_waddr_s = '0;
      sel_wdata_s = '0;
      if (lsu_rvalid_i) begin
         src_s = fifo_empty_s ? WB_SRC_NONE : WB_SRC_LSU;
      end else if (ex_valid_i) begin
         src_s = WB_SRC_EX;
      end else begin
         src_s = WB_SRC_NONE;
      end
      case (src_s)
         WB_SRC_LSU: begin
            sel_waddr_s = head_waddr_s;
            sel_wdata_s = lsu_rdata_i;
         end
         WB_SRC_EX: begin
            sel_waddr_s = ex_waddr_i;
            sel_wdata_s = ex_wdata_i;
         end
         default: begin
            sel_waddr_s = '0;
            sel_wdata_s = '0;
         end
      endcase
      sel_we_s = (src_s != WB_SRC_NONE) && (sel_waddr_s != '0);
   end

   // RF write-port register; address and data hold their last written value when idle.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rf_we_r    <= 1'b0;
         rf_waddr_r <= '0;
         rf_wdata_r <= '0;
      end else begin
         rf_we_r <= sel_we_s;
         if (sel_we_s) begin
            rf_waddr_r <= sel_waddr_s;
            rf_wdata_r <= sel_wdata_s;
         end
      end
   end

   // Sticky protocol error: orphan load return or push into a full FIFO without a pop.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         err_r <= 1'b0;
      end else begin
         err_r <= err_r | (lsu_rvalid_i && fifo_empty_s) | (ld_issue_i && !ld_issue_ready_o);
      end
   end

   assign rf_we_o    = rf_we_r;
   assign rf_waddr_o = rf_waddr_r;
   assign rf_wdata_o = rf_wdata_r;
   assign err_o      = err_r;

   // Match decode read addresses against every pending load destination.
   always_comb begin
      pend_a_s = 1'b0;
      pend_b_s = 1'b0;
      for (int i = 0; i < LoadDepth; i++) begin
         pend_a_s = pend_a_s | (slot_valid_s[i] && (slot_waddr_s[i*AddrWidth +: AddrWidth] == raddr_a_i));
         pend_b_s = pend_b_s | (slot_valid_s[i] && (slot_waddr_s[i*AddrWidth +: AddrWidth] == raddr_b_i));
      end
   end

`ifdef IBEX_WB_BYPASS_EN
   assign fwd_a_o    = rf_we_r && (rf_waddr_r == raddr_a_i) && (raddr_a_i != '0);
   assign fwd_b_o    = rf_we_r && (rf_waddr_r == raddr_b_i) && (raddr_b_i != '0);
   assign fwd_data_o = rf_wdata_r;
   assign hazard_a_o = (raddr_a_i != '0) && pend_a_s;
   assign hazard_b_o = (raddr_b_i != '0) && pend_b_s;
`else
   // Without forwarding, the write sitting on the RF port costs decode one stall cycle.
   assign hazard_a_o = (raddr_a_i != '0) && (pend_a_s || (rf_we_r && (rf_waddr_r == raddr_a_i)));
   assign hazard_b_o = (raddr_b_i != '0) && (pend_b_s || (rf_we_r && (rf_waddr_r == raddr_b_i)));
`endif

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Scoreboard bench for ibex_rf_wb_arbiter (default parameters); also covers IBEX_WB_BYPASS_EN.
module tb_ibex_rf_wb_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;
`ifdef IBEX_WB_BYPASS_EN
   localparam bit Bypass = 1'b1;
`else
   localparam bit Bypass = 1'b0;
`endif

   logic          clk;
   logic          rst_ni;
   logic          ex_valid;
   logic [AW-1:0] ex_waddr;
   logic [DW-1:0] ex_wdata;
   logic          ex_ready;
   logic          ld_issue;
   logic [AW-1:0] ld_waddr;
   logic          ld_issue_ready;
   logic          lsu_rvalid;
   logic [DW-1:0] lsu_rdata;
   logic [AW-1:0] raddr_a;
   logic [AW-1:0] raddr_b;
   logic          hazard_a;
   logic          hazard_b;
`ifdef IBEX_WB_BYPASS_EN
   logic          fwd_a;
   logic          fwd_b;
   logic [DW-1:0] fwd_data;
`endif
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic          rf_we;
   logic          err;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_w;
   int  n_checks = 0;
   int  n_fail   = 0;

   ibex_rf_wb_arbiter dut (
      .clk_i            (clk),
      .rst_ni           (rst_ni),
      .ex_valid_i       (ex_valid),
      .ex_waddr_i       (ex_waddr),
      .ex_wdata_i       (ex_wdata),
      .ex_ready_o       (ex_ready),
      .ld_issue_i       (ld_issue),
      .ld_waddr_i       (ld_waddr),
      .ld_issue_ready_o (ld_issue_ready),
      .lsu_rvalid_i     (lsu_rvalid),
      .lsu_rdata_i      (lsu_rdata),
      .raddr_a_i        (raddr_a),
      .raddr_b_i        (raddr_b),
      .hazard_a_o       (hazard_a),
      .hazard_b_o       (hazard_b),
`ifdef IBEX_WB_BYPASS_EN
      .fwd_a_o          (fwd_a),
      .fwd_b_o          (fwd_b),
      .fwd_data_o       (fwd_data),
`endif
      .rf_waddr_o       (rf_waddr),
      .rf_wdata_o       (rf_wdata),
      .rf_we_o          (rf_we),
      .err_o            (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_q.push_back(w);
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ex_valid   = 1'b0;
      ex_waddr   = '0;
      ex_wdata   = '0;
      ld_issue   = 1'b0;
      ld_waddr   = '0;
      lsu_rvalid = 1'b0;
      lsu_rdata  = '0;
   endtask

   // Monitor: every RF write must match the oldest expected write.
   always @(negedge clk) begin
      if (rf_we === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rf_write_unexpected: got x%0d=0x%08h, expected no write", rf_waddr, rf_wdata);
         end else begin
            mon_w = exp_q.pop_front();
            if (rf_waddr !== mon_w.addr || rf_wdata !== mon_w.data) begin
               n_fail++;
               $display("FAIL rf_write: got x%0d=0x%08h, expected x%0d=0x%08h",
                        rf_waddr, rf_wdata, mon_w.addr, mon_w.data);
            end
         end
      end
   end

   initial begin
      idle();
      rst_ni  = 1'b0;
      raddr_a = '0;
      raddr_b = '0;
      step(2);
      chk("rst_we", rf_we, 0);
      chk("rst_waddr", rf_waddr, 0);
      chk("rst_wdata", rf_wdata, 0);
      chk("rst_err", err, 0);
      chk("rst_ld_ready", ld_issue_ready, 1);
      chk("rst_haz_a", hazard_a, 0);
      rst_ni = 1'b1;
      step();

      // 1: plain EX write
      ex_valid = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'hDEADBEEF;
      #1 chk("t1_ex_ready", ex_ready, 1);
      expect_wr(5'd5, 32'hDEADBEEF);
      step(); idle(); raddr_a = 5'd5; raddr_b = 5'd6;
      #1 chk("t1_haz_a_inflight", hazard_a, !Bypass);
      chk("t1_haz_b", hazard_b, 0);
`ifdef IBEX_WB_BYPASS_EN
      chk("t1_fwd_a", fwd_a, 1);
      chk("t1_fwd_b", fwd_b, 0);
      chk("t1_fwd_data", fwd_data, 32'hDEADBEEF);
`endif
      step();
      chk("t1_haz_a_clear", hazard_a, 0);

      // 2: LSU return beats a simultaneous EX result
      ld_issue = 1'b1; ld_waddr = 5'd7;
      step(); idle(); raddr_a = 5'd7;
      #1 chk("t2_haz_pending", hazard_a, 1);
      ex_valid = 1'b1; ex_waddr = 5'd8; ex_wdata = 32'h00000055;
      lsu_rvalid = 1'b1; lsu_rdata = 32'h00001234;
      #1 chk("t2_ex_ready_lsu", ex_ready, 0);
      expect_wr(5'd7, 32'h00001234);
      step(); lsu_rvalid = 1'b0;
      #1 chk("t2_ex_ready_after", ex_ready, 1);
      chk("t2_haz_inflight", hazard_a, !Bypass);
`ifdef IBEX_WB_BYPASS_EN
      chk("t2_fwd_a", fwd_a, 1);
      chk("t2_fwd_data", fwd_data, 32'h00001234);
`endif
      expect_wr(5'd8, 32'h00000055);
      step(); idle(); step();

      // 3: full FIFO, hazards, return + issue in the same cycle
      ld_issue = 1'b1; ld_waddr = 5'd3; step();
      ld_waddr = 5'd4; step();
      ld_issue = 1'b0; raddr_a = 5'd4; raddr_b = 5'd3;
      #1 chk("t3_ld_ready_full", ld_issue_ready, 0);
      chk("t3_haz_a", hazard_a, 1);
      chk("t3_haz_b", hazard_b, 1);
      lsu_rvalid = 1'b1; lsu_rdata = 32'hAAAA0003; ld_issue = 1'b1; ld_waddr = 5'd9;
      #1 chk("t3_ld_ready_pop", ld_issue_ready, 1);
      expect_wr(5'd3, 32'hAAAA0003);
      step(); idle(); raddr_a = 5'd9; raddr_b = 5'd3;
      #1 chk("t3_err", err, 0);
      chk("t3_haz_new", hazard_a, 1);
      chk("t3_haz_b_inflight", hazard_b, !Bypass);
      chk("t3_ld_ready_refull", ld_issue_ready, 0);
      lsu_rvalid = 1'b1; lsu_rdata = 32'h00000044; expect_wr(5'd4, 32'h00000044);
      step(); lsu_rdata = 32'h00000099; expect_wr(5'd9, 32'h00000099);
      step(); idle(); step();
      chk("t3_drained_haz", hazard_a, 0);
      chk("t3_drained_ready", ld_issue_ready, 1);

      // 4: orphan return
      lsu_rvalid = 1'b1; lsu_rdata = 32'h00000BAD;
      step(); idle();
      #1 chk("t4_err", err, 1);
      step(3);
      chk("t4_err_sticky", err, 1);

      // 5: x0 destinations
      ex_valid = 1'b1; ex_waddr = 5'd0; ex_wdata = 32'h0000FFFF;
      step(); idle(); raddr_a = 5'd0;
      #1 chk("t5_we_x0", rf_we, 0);
      chk("t5_haz_x0", hazard_a, 0);
`ifdef IBEX_WB_BYPASS_EN
      chk("t5_fwd_x0", fwd_a, 0);
`endif
      ld_issue = 1'b1; ld_waddr = 5'd0;
      step(); idle();
      #1 chk("t5_haz_ld_x0", hazard_a, 0);
      lsu_rvalid = 1'b1; lsu_rdata = 32'h00000077;
      step(); idle();
      ld_issue = 1'b1; ld_waddr = 5'd10;
      step(); idle();
      #1 chk("t5_x0_popped", ld_issue_ready, 1);
      ld_issue = 1'b1; ld_waddr = 5'd11;
      ex_valid = 1'b1; ex_waddr = 5'd12; ex_wdata = 32'h12121212;
      expect_wr(5'd12, 32'h12121212);
      step(); idle();
      #1 chk("t5_full", ld_issue_ready, 0);

      // 6: reset mid-traffic with two loads pending
      rst_ni = 1'b0; ex_valid = 1'b1; ex_waddr = 5'd13; ex_wdata = 32'h13131313;
      step(); idle(); raddr_a = 5'd10; raddr_b = 5'd11;
      #1 chk("t6_we", rf_we, 0);
      chk("t6_waddr", rf_waddr, 0);
      chk("t6_wdata", rf_wdata, 0);
      chk("t6_err", err, 0);
      chk("t6_ld_ready", ld_issue_ready, 1);
      chk("t6_haz_a", hazard_a, 0);
      chk("t6_haz_b", hazard_b, 0);
      rst_ni = 1'b1;
      step();

      ex_valid = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'h0BADF00D;
      expect_wr(5'd5, 32'h0BADF00D);
      step(); idle(); raddr_a = 5'd5;
      #1 chk("r1_haz_inflight", hazard_a, !Bypass);
`ifdef IBEX_WB_BYPASS_EN
      chk("r1_fwd_a", fwd_a, 1);
      chk("r1_fwd_data", fwd_data, 32'h0BADF00D);
`endif
      step();
      ld_issue = 1'b1; ld_waddr = 5'd3; step();
      ld_waddr = 5'd4; step(); idle(); raddr_a = 5'd4;
      #1 chk("r3_ld_ready_full", ld_issue_ready, 0);
      chk("r3_haz_a", hazard_a, 1);
      ld_issue = 1'b1; ld_waddr = 5'd13;
      step(); idle(); raddr_a = 5'd13; raddr_b = 5'd3;
      #1 chk("r3_err_overflow", err, 1);
      chk("r3_haz_ignored", hazard_a, 0);
      chk("r3_haz_b", hazard_b, 1);
      lsu_rvalid = 1'b1; lsu_rdata = 32'h00000033; expect_wr(5'd3, 32'h00000033);
      step(); lsu_rdata = 32'h00000444; expect_wr(5'd4, 32'h00000444);
      step(); idle();
      step(3);
      chk("sb_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
